// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and flush-then-redirect trap sequencer fed by the commit stage.
// Define TRAP_VECTORED_EN to make mtvec vectored mode (MODE=01) available for interrupts.
module trap_csr_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        commit_valid,
  input  logic [31:0] csr_wb,
  input  logic [11:0] csr_wb_addr,
  input  logic        csr_we,
  input  logic [31:0] pc_exc,
  input  logic [31:0] cause,
  input  logic        exception_pending,
  input  logic        mret,
  input  logic        sret,
  input  logic        uret,
  input  logic        ext_irq,
  input  logic [11:0] csr_rd_addr,
  output logic [31:0] csr_rd_data,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMip      = 12'h344;

  localparam logic [31:0] IrqCause = 32'h8000_000B;
  localparam logic [3:0]  CntLoad  = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic        meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        flush_q, redirect_q;
  logic [31:0] redirect_pc_q;

  logic        idle, take_exc, take_mret, take_irq, do_write;
  logic [1:0]  wb_mode;
  logic [31:0] vec_base;
  logic [31:0] pc_next;

  // sret/uret have no architectural effect on an M-mode-only core
  logic unused_xret;
  assign unused_xret = sret ^ uret;

  assign idle      = (state_q == StIdle);
  assign take_exc  = idle & exception_pending;
  assign take_mret = idle & ~exception_pending & mret;
  assign take_irq  = idle & ~exception_pending & ~mret &
                     commit_valid & ext_irq & mst_mie_q & meie_q;
  assign do_write  = idle & csr_we & ~exception_pending & ~mret;
  assign pc_next   = pc_exc + 32'd4;

`ifdef TRAP_VECTORED_EN
  assign wb_mode = (csr_wb[1:0] == 2'b01) ? 2'b01 : 2'b00;
`else
  assign wb_mode = 2'b00;
`endif

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    target_d   = target_q;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (do_write) begin
      case (csr_wb_addr)
        AddrMstatus: begin
          mst_mie_d  = csr_wb[3];
          mst_mpie_d = csr_wb[7];
        end
        AddrMie:      meie_d     = csr_wb[11];
        AddrMtvec:    mtvec_d    = {csr_wb[31:2], wb_mode};
        AddrMscratch: mscratch_d = csr_wb;
        AddrMepc:     mepc_d     = {csr_wb[31:2], 2'b00};
        AddrMcause:   mcause_d   = csr_wb;
        default: ;
      endcase
    end

    vec_base = {mtvec_d[31:2], 2'b00};

    // Trap fields take precedence over a same-cycle CSR write
    if (take_exc) begin
      mepc_d     = {pc_exc[31:2], 2'b00};
      mcause_d   = cause;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      target_d   = vec_base;
    end else if (take_mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
      target_d   = mepc_q;
    end else if (take_irq) begin
      mepc_d     = {pc_next[31:2], 2'b00};
      mcause_d   = IrqCause;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      target_d   = (mtvec_d[1:0] == 2'b01) ? vec_base + {25'b0, IrqCause[4:0], 2'b00}
                                           : vec_base;
    end

    unique case (state_q)
      StIdle: begin
        if (take_exc || take_mret || take_irq) begin
          state_d = StFlush;
          cnt_d   = CntLoad;
        end
      end
      StFlush: begin
        if (cnt_q == 4'd0) begin
          state_d = StRedirect;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      target_q      <= 32'd0;
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      meie_q        <= 1'b0;
      mtvec_q       <= RESET_MTVEC;
      mscratch_q    <= 32'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      meie_q        <= meie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      flush_q       <= (state_d != StIdle);
      redirect_q    <= (state_d == StRedirect);
      redirect_pc_q <= (state_d == StRedirect) ? target_d : 32'd0;
    end
  end

  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

  always_comb begin
    csr_rd_data = 32'd0;
    case (csr_rd_addr)
      AddrMstatus:  csr_rd_data = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
      AddrMie:      csr_rd_data = {20'b0, meie_q, 11'b0};
      AddrMip:      csr_rd_data = {20'b0, ext_irq, 11'b0};
      AddrMtvec:    csr_rd_data = mtvec_q;
      AddrMscratch: csr_rd_data = mscratch_q;
      AddrMepc:     csr_rd_data = mepc_q;
      AddrMcause:   csr_rd_data = mcause_q;
      default:      csr_rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed self-checking bench for trap_csr_unit (FLUSH_CYCLES=2, mtvec reset 0x100).
module tb_trap_csr_unit;

  logic        clk;
  logic        nrst;
  logic        commit_valid;
  logic [31:0] csr_wb;
  logic [11:0] csr_wb_addr;
  logic        csr_we;
  logic [31:0] pc_exc;
  logic [31:0] cause;
  logic        exception_pending;
  logic        mret, sret, uret;
  logic        ext_irq;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        flush, redirect;
  logic [31:0] redirect_pc;

  int nvec  = 0;
  int nfail = 0;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] ExpMtvec  = 32'h0000_2001;
  localparam logic [31:0] ExpIrqTgt = 32'h0000_202C;
`else
  localparam logic [31:0] ExpMtvec  = 32'h0000_2000;
  localparam logic [31:0] ExpIrqTgt = 32'h0000_2000;
`endif

  trap_csr_unit #(
    .FLUSH_CYCLES(2),
    .RESET_MTVEC (32'h0000_0100)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .commit_valid     (commit_valid),
    .csr_wb           (csr_wb),
    .csr_wb_addr      (csr_wb_addr),
    .csr_we           (csr_we),
    .pc_exc           (pc_exc),
    .cause            (cause),
    .exception_pending(exception_pending),
    .mret             (mret),
    .sret             (sret),
    .uret             (uret),
    .ext_irq          (ext_irq),
    .csr_rd_addr      (csr_rd_addr),
    .csr_rd_data      (csr_rd_data),
    .flush            (flush),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_rd_addr = addr;
    #1;
    check(tag, csr_rd_data, exp);
  endtask

  task automatic outs(input string tag, input logic f, input logic r, input logic [31:0] pc);
    check({tag, ".flush"}, {31'b0, flush}, {31'b0, f});
    check({tag, ".redirect"}, {31'b0, redirect}, {31'b0, r});
    check({tag, ".redirect_pc"}, redirect_pc, pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    commit_valid      = 1'b0;
    csr_wb            = 32'd0;
    csr_wb_addr       = 12'd0;
    csr_we            = 1'b0;
    pc_exc            = 32'd0;
    cause             = 32'd0;
    exception_pending = 1'b0;
    mret              = 1'b0;
    sret              = 1'b0;
    uret              = 1'b0;
    ext_irq           = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    commit_valid = 1'b1;
    csr_we       = 1'b1;
    csr_wb_addr  = addr;
    csr_wb       = data;
    step();
    clear_inputs();
  endtask

  initial begin
    nrst        = 1'b0;
    csr_rd_addr = 12'd0;
    clear_inputs();
    #12;
    // Reset state
    rd("rst.mstatus", 12'h300, 32'h0000_1800);
    rd("rst.mtvec", 12'h305, 32'h0000_0100);
    rd("rst.mepc", 12'h341, 32'h0000_0000);
    outs("rst", 1'b0, 1'b0, 32'h0);
    nrst = 1'b1;
    step();

    // mtvec write with MODE=01
    csr_write(12'h305, 32'h0000_2001);
    rd("mtvec.wr", 12'h305, ExpMtvec);
    rd("unimpl", 12'h7C0, 32'h0);

    // sret/uret do nothing
    commit_valid = 1'b1;
    sret         = 1'b1;
    uret         = 1'b1;
    step();
    clear_inputs();
    outs("sret", 1'b0, 1'b0, 32'h0);

    // Exception with MIE=1
    csr_write(12'h300, 32'h0000_0008);
    rd("mstatus.mie", 12'h300, 32'h0000_1808);
    commit_valid      = 1'b1;
    exception_pending = 1'b1;
    pc_exc            = 32'h0000_1004;
    cause             = 32'd2;
    step();
    clear_inputs();
    rd("exc.mepc", 12'h341, 32'h0000_1004);
    rd("exc.mcause", 12'h342, 32'h0000_0002);
    rd("exc.mstatus", 12'h300, 32'h0000_1880);
    outs("exc.f1", 1'b1, 1'b0, 32'h0);
    step();
    outs("exc.f2", 1'b1, 1'b0, 32'h0);
    step();
    outs("exc.f3", 1'b1, 1'b1, 32'h0000_2000);
    step();
    outs("exc.done", 1'b0, 1'b0, 32'h0);

    // mret
    commit_valid = 1'b1;
    mret         = 1'b1;
    step();
    clear_inputs();
    rd("mret.mstatus", 12'h300, 32'h0000_1888);
    outs("mret.f1", 1'b1, 1'b0, 32'h0);
    step();
    step();
    outs("mret.f3", 1'b1, 1'b1, 32'h0000_1004);
    step();
    outs("mret.done", 1'b0, 1'b0, 32'h0);

    // External interrupt alongside a mscratch write
    csr_write(12'h304, 32'h0000_0800);
    rd("mie.meie", 12'h304, 32'h0000_0800);
    commit_valid = 1'b1;
    ext_irq      = 1'b1;
    pc_exc       = 32'h0000_3000;
    csr_we       = 1'b1;
    csr_wb_addr  = 12'h340;
    csr_wb       = 32'h0000_00AA;
    step();
    commit_valid = 1'b0;
    csr_we       = 1'b0;
    rd("irq.mip", 12'h344, 32'h0000_0800);
    rd("irq.mscratch", 12'h340, 32'h0000_00AA);
    rd("irq.mepc", 12'h341, 32'h0000_3004);
    rd("irq.mcause", 12'h342, 32'h8000_000B);
    clear_inputs();
    rd("irq.mstatus", 12'h300, 32'h0000_1880);
    outs("irq.f1", 1'b1, 1'b0, 32'h0);
    step();
    step();
    outs("irq.f3", 1'b1, 1'b1, ExpIrqTgt);
    step();

    // Exception beats a simultaneous interrupt; events during FLUSH are ignored
    csr_write(12'h300, 32'h0000_0008);
    commit_valid      = 1'b1;
    exception_pending = 1'b1;
    ext_irq           = 1'b1;
    pc_exc            = 32'h0000_4000;
    cause             = 32'd5;
    step();
    rd("both.mcause", 12'h342, 32'h0000_0005);
    rd("both.mepc", 12'h341, 32'h0000_4000);
    pc_exc = 32'h0000_5000;
    cause  = 32'd7;
    step();
    rd("flush2.mcause", 12'h342, 32'h0000_0005);
    rd("flush2.mepc", 12'h341, 32'h0000_4000);
    outs("flush2", 1'b1, 1'b0, 32'h0);

    // Reset during FLUSH drops the pending redirect
    clear_inputs();
    nrst = 1'b0;
    #1;
    outs("rstmid", 1'b0, 1'b0, 32'h0);
    rd("rstmid.mcause", 12'h342, 32'h0);
    rd("rstmid.mtvec", 12'h305, 32'h0000_0100);
    #1;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      outs("post_rst", 1'b0, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
